clk_enable_sched: RTL and testbench

Clock-enable scheduler for the system's PLL-derived master clock. Replaces ripple-counter clock division: all downstream logic (VDP, sound generator, I2S serializer) runs on the single PLL clock. They are gated by single-cycle enables produced by fractional phase accumulators, so average rates track their targets instead of power-of-two divisions. A lock-qualification state machine holds every enable low until the PLL lock has been stable for a programmable settle time, and drops them immediately when lock is lost.

---
 rtl/clk_enable_sched_if.sv | 21 ++
 rtl/clk_enable_sched.sv | 157 +++++++++++++++
 tb/tb_clk_enable_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/clk_enable_sched_if.sv
// Lock input and enable/status outputs of the clock-enable scheduler.
// The slave side is the scheduler; the master side is the PLL/consumer view.
interface clk_enable_sched_if;
  logic       locked;
  logic       vdp_ce;
  logic       snd_ce;
  logic       i2s_ce;
  logic       i2s_lrck;
  logic       running;
  logic [7:0] lock_loss_cnt;

  modport master (
    output locked,
    input  vdp_ce, snd_ce, i2s_ce, i2s_lrck, running, lock_loss_cnt
  );

  modport slave (
    input  locked,
    output vdp_ce, snd_ce, i2s_ce, i2s_lrck, running, lock_loss_cnt
  );
endinterface

// File: rtl/clk_enable_sched.sv
// Fractional clock-enable generator gated by a PLL lock-qualification FSM.
// Enables are carry-outs of phase accumulators, delayed one register stage.
module clk_enable_sched #(
  parameter int unsigned ACC_W         = 32'd24,
  parameter int unsigned VDP_INC       = 32'd5490683,
  parameter int unsigned SND_INC       = 32'd228781,
  parameter int unsigned I2S_INC       = 32'd1570730,
  parameter int unsigned SETTLE_CYCLES = 32'd1024,
  parameter int unsigned LR_BITS       = 32'd32
) (
  input  logic               clock_in,
  input  logic               reset_n,
  clk_enable_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  localparam logic [ACC_W:0] VDP_STEP    = (ACC_W + 1)'(VDP_INC);
  localparam logic [ACC_W:0] SND_STEP    = (ACC_W + 1)'(SND_INC);
  localparam logic [ACC_W:0] I2S_STEP    = (ACC_W + 1)'(I2S_INC);
  localparam logic [15:0]    SETTLE_LAST = 16'(SETTLE_CYCLES - 32'd1);
  localparam logic [7:0]     LR_LAST     = 8'(LR_BITS - 32'd1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_loss;
  logic               w_stay;
  logic               r_sync1;
  logic               r_lock_s;
  logic [15:0]        r_settle_cnt;
  logic               r_running;
  logic [7:0]         r_loss_cnt;
  logic [ACC_W-1:0]   r_vdp_acc;
  logic [ACC_W-1:0]   r_snd_acc;
  logic [ACC_W-1:0]   r_i2s_acc;
  logic [ACC_W:0]     w_vdp_sum;
  logic [ACC_W:0]     w_snd_sum;
  logic [ACC_W:0]     w_i2s_sum;
  logic               r_vdp_cy;
  logic               r_snd_cy;
  logic               r_i2s_cy;
  logic               r_vdp_ce;
  logic               r_snd_ce;
  logic               r_i2s_ce;
  logic [7:0]         r_lr_cnt;
  logic               r_lrck;

  // Next-state logic; lock loss from RUN is flagged for the loss counter.
  always_comb begin
    w_state_nxt = r_state;
    w_loss      = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (r_lock_s) w_state_nxt = ST_SETTLE;
        else          w_state_nxt = ST_WAIT_LOCK;
      end
      ST_SETTLE: begin
        if (!r_lock_s)                        w_state_nxt = ST_WAIT_LOCK;
        else if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_RUN;
        else                                  w_state_nxt = ST_SETTLE;
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_loss      = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Datapath only advances on cycles that are in RUN and stay in RUN, so a
  // carry produced on the exiting cycle never reaches a ce output.
  assign w_stay    = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
  assign w_vdp_sum = {1'b0, r_vdp_acc} + VDP_STEP;
  assign w_snd_sum = {1'b0, r_snd_acc} + SND_STEP;
  assign w_i2s_sum = {1'b0, r_i2s_acc} + I2S_STEP;

  // Lock synchronizer, state register, settle counter and loss counter.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_sync1      <= 1'b0;
      r_lock_s     <= 1'b0;
      r_state      <= ST_WAIT_LOCK;
      r_running    <= 1'b0;
      r_settle_cnt <= 16'd0;
      r_loss_cnt   <= 8'd0;
    end else begin
      r_sync1   <= bus.locked;
      r_lock_s  <= r_sync1;
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      if ((r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE)) begin
        r_settle_cnt <= r_settle_cnt + 16'd1;
      end else begin
        r_settle_cnt <= 16'd0;
      end
      if (w_loss && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end else begin
        r_loss_cnt <= r_loss_cnt;
      end
    end
  end

  // Phase accumulators, carry stage, ce stage and LR word-select framing.
  always_ff @(posedge clock_in) begin
    if (!reset_n || !w_stay) begin
      r_vdp_acc <= '0;
      r_snd_acc <= '0;
      r_i2s_acc <= '0;
      r_vdp_cy  <= 1'b0;
      r_snd_cy  <= 1'b0;
      r_i2s_cy  <= 1'b0;
      r_vdp_ce  <= 1'b0;
      r_snd_ce  <= 1'b0;
      r_i2s_ce  <= 1'b0;
      r_lr_cnt  <= 8'd0;
      r_lrck    <= 1'b0;
    end else begin
      r_vdp_acc <= w_vdp_sum[ACC_W-1:0];
      r_snd_acc <= w_snd_sum[ACC_W-1:0];
      r_i2s_acc <= w_i2s_sum[ACC_W-1:0];
      r_vdp_cy  <= w_vdp_sum[ACC_W];
      r_snd_cy  <= w_snd_sum[ACC_W];
      r_i2s_cy  <= w_i2s_sum[ACC_W];
      r_vdp_ce  <= r_vdp_cy;
      r_snd_ce  <= r_snd_cy;
      r_i2s_ce  <= r_i2s_cy;
      // Framing moves on the same edge that raises i2s_ce.
      if (r_i2s_cy) begin
        if (r_lr_cnt == LR_LAST) begin
          r_lr_cnt <= 8'd0;
          r_lrck   <= ~r_lrck;
        end else begin
          r_lr_cnt <= r_lr_cnt + 8'd1;
        end
      end else begin
        r_lr_cnt <= r_lr_cnt;
      end
    end
  end

  assign bus.vdp_ce        = r_vdp_ce;
  assign bus.snd_ce        = r_snd_ce;
  assign bus.i2s_ce        = r_i2s_ce;
  assign bus.i2s_lrck      = r_lrck;
  assign bus.running       = r_running;
  assign bus.lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_clk_enable_sched.sv
// Directed bench: instance A exercises rates, lock loss and reset mid-RUN;
// instance B exercises settle abort and LR framing.
module tb_clk_enable_sched;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  clk_enable_sched_if if_a ();
  clk_enable_sched_if if_b ();

  clk_enable_sched #(
    .ACC_W(32'd4), .VDP_INC(32'd8), .SND_INC(32'd4), .I2S_INC(32'd3),
    .SETTLE_CYCLES(32'd4), .LR_BITS(32'd2)
  ) dut_a (.clock_in(clk), .reset_n(rst_a_n), .bus(if_a));

  clk_enable_sched #(
    .ACC_W(32'd4), .VDP_INC(32'd8), .SND_INC(32'd4), .I2S_INC(32'd8),
    .SETTLE_CYCLES(32'd8), .LR_BITS(32'd2)
  ) dut_b (.clock_in(clk), .reset_n(rst_b_n), .bus(if_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({if_a.vdp_ce, if_a.snd_ce, if_a.i2s_ce, if_a.i2s_lrck, if_a.running});
  endfunction

  function automatic logic [31:0] outs_b();
    return 32'({if_b.vdp_ce, if_b.snd_ce, if_b.i2s_ce, if_b.i2s_lrck, if_b.running});
  endfunction

  initial begin
    int n_vdp = 0, n_snd = 0, n_i2s = 0;
    int first_vdp = -1, first_snd = -1, first_i2s = -1;
    int last_snd = -1, last_i2s = -1;
    int bad_vdp = 0, bad_snd = 0, bad_i2s = 0, bad_lr = 0, n_tog = 0;
    logic prev_vdp = 1'b0, prev_lr = 1'b0;
    int waited = 0, run_seen = 0;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    if_a.locked = 1'b1;
    if_b.locked = 1'b0;
    tick(3);
    chk("reset_outs_a", outs_a(), 32'd0);
    chk("reset_llc_a", 32'(if_a.lock_loss_cnt), 32'd0);
    chk("reset_outs_b", outs_b(), 32'd0);

    // Release: running rises on the 7th edge (2 sync + 1 + 4 settle).
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    tick(6);
    chk("run_early_a", 32'(if_a.running), 32'd0);
    tick(1);
    chk("run_rise_a", 32'(if_a.running), 32'd1);

    // k = 0 is the first RUN cycle; window 2..481 covers 480 accumulation cycles.
    for (int k = 0; k < 482; k++) begin
      if (k >= 2) begin
        n_vdp += int'(if_a.vdp_ce);
        n_snd += int'(if_a.snd_ce);
        n_i2s += int'(if_a.i2s_ce);
      end
      if (if_a.vdp_ce && first_vdp < 0) first_vdp = k;
      if (if_a.vdp_ce && prev_vdp) bad_vdp++;
      if (if_a.snd_ce) begin
        if (first_snd < 0) first_snd = k;
        if (last_snd >= 0 && (k - last_snd) != 4) bad_snd++;
        last_snd = k;
      end
      if (if_a.i2s_ce) begin
        if (first_i2s < 0) first_i2s = k;
        if (last_i2s >= 0 && ((k - last_i2s) < 5 || (k - last_i2s) > 6)) bad_i2s++;
        last_i2s = k;
      end
      if (if_a.i2s_lrck != prev_lr) begin
        if (if_a.i2s_ce) n_tog++;
        else bad_lr++;
      end
      prev_vdp = if_a.vdp_ce;
      prev_lr  = if_a.i2s_lrck;
      tick(1);
    end
    chk("vdp_count", 32'(n_vdp), 32'd240);
    chk("snd_count", 32'(n_snd), 32'd120);
    chk("i2s_count", 32'(n_i2s), 32'd90);
    chk("vdp_first", 32'(first_vdp), 32'd3);
    chk("snd_first", 32'(first_snd), 32'd5);
    chk("i2s_first", 32'(first_i2s), 32'd7);
    chk("vdp_back_to_back", 32'(bad_vdp), 32'd0);
    chk("snd_spacing", 32'(bad_snd), 32'd0);
    chk("i2s_spacing", 32'(bad_i2s), 32'd0);
    chk("lrck_toggles", 32'(n_tog), 32'd45);
    chk("lrck_off_pulse", 32'(bad_lr), 32'd0);

    // Lock loss: outputs drop on the 3rd edge after locked falls.
    if_a.locked = 1'b0;
    tick(2);
    chk("loss_still_run", 32'(if_a.running), 32'd1);
    tick(1);
    chk("loss_outs", outs_a(), 32'd0);
    chk("loss_llc1", 32'(if_a.lock_loss_cnt), 32'd1);

    for (int i = 0; i < 299; i++) begin
      if_a.locked = 1'b1;
      tick(7);
      run_seen += int'(if_a.running);
      if_a.locked = 1'b0;
      tick(3);
      if (i == 8) chk("llc_10", 32'(if_a.lock_loss_cnt), 32'd10);
    end
    chk("relock_runs", 32'(run_seen), 32'd299);
    chk("llc_saturate", 32'(if_a.lock_loss_cnt), 32'd255);

    // Reset mid-RUN while vdp_ce is high.
    if_a.locked = 1'b1;
    tick(7);
    chk("rerun_a", 32'(if_a.running), 32'd1);
    while (!if_a.vdp_ce && waited < 20) begin
      tick(1);
      waited++;
    end
    chk("vdp_seen", 32'(waited < 20), 32'd1);
    rst_a_n = 1'b0;
    tick(1);
    chk("midrun_reset_outs", outs_a(), 32'd0);
    chk("midrun_reset_llc", 32'(if_a.lock_loss_cnt), 32'd0);
    rst_a_n = 1'b1;
    tick(6);
    chk("requal_early", 32'(if_a.running), 32'd0);
    tick(1);
    chk("requal_rise", 32'(if_a.running), 32'd1);

    // Settle abort on B: 5 settle cycles, locked low for 2 edges, then back.
    chk("b_idle", outs_b(), 32'd0);
    if_b.locked = 1'b1;
    tick(7);
    if_b.locked = 1'b0;
    tick(2);
    if_b.locked = 1'b1;
    run_seen = 0;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      run_seen += int'(if_b.running);
    end
    chk("abort_no_run", 32'(run_seen), 32'd0);
    tick(1);
    chk("abort_run_rise", 32'(if_b.running), 32'd1);
    chk("abort_llc", 32'(if_b.lock_loss_cnt), 32'd0);

    // LR framing on B: i2s_ce at odd k >= 3, lrck toggles at k = 5, 9, 13, 17.
    for (int k = 0; k < 21; k++) begin
      chk("b_i2s_ce", 32'(if_b.i2s_ce), 32'((k >= 3) && (k % 2 == 1)));
      chk("b_lrck", 32'(if_b.i2s_lrck), 32'((k >= 5) && (((k - 5) / 4) % 2 == 0)));
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
